// File: rtl/mvm_pkg.sv
// Shared types and helpers for the streaming matrix-vector multiply-accumulator.
// Contents: default width constants, FSM state enum, saturating-add result struct,
// ext_x() sign/zero extension and sat_add() clamped addition on a 64-bit working width.
package mvm_pkg;

   localparam int unsigned DEF_DIM     = 256;
   localparam int unsigned DEF_NUM_BIT = 8;
   localparam int unsigned DEF_WT_BIT  = 8;
   localparam int unsigned DEF_ACC_BIT = 24;
   localparam int unsigned DEF_MAX_VEC = 128;

   // Working width for extension/add helpers; all operand widths must stay below it.
   localparam int unsigned EXT_W  = 64;
   localparam int unsigned EXT_IW = 6;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RECV = 2'd1,
      MAC  = 2'd2,
      DONE = 2'd3
   } mvm_state_e;

   typedef struct packed {
      logic             sat;
      logic [EXT_W-1:0] val;
   } sat_res_t;

   // Extend the low w bits of v to EXT_W bits, sign-extending when sgn is set.
   function automatic logic [EXT_W-1:0] ext_x(input logic [EXT_W-1:0] v,
                                              input int unsigned w,
                                              input logic sgn);
      logic [EXT_W-1:0] mask;
      logic [EXT_W-1:0] r;
      mask = (EXT_W'(1) << w) - EXT_W'(1);
      r    = v & mask;
      if (sgn && v[EXT_IW'(w - 1)]) r = r | ~mask;
      return r;
   endfunction

   // Signed add of two EXT_W operands, clamped to a w-bit signed range.
   function automatic sat_res_t sat_add(input logic [EXT_W-1:0] a,
                                        input logic [EXT_W-1:0] b,
                                        input int unsigned w);
      logic signed [EXT_W-1:0] s;
      logic signed [EXT_W-1:0] hi;
      logic signed [EXT_W-1:0] lo;
      sat_res_t r;
      s  = $signed(a) + $signed(b);
      hi = $signed((EXT_W'(1) << (w - 1)) - EXT_W'(1));
      lo = ~hi;
      r.sat = 1'b0;
      r.val = s;
      if (s > hi) begin
         r.sat = 1'b1;
         r.val = hi;
      end else if (s < lo) begin
         r.sat = 1'b1;
         r.val = lo;
      end
      return r;
   endfunction

endpackage

// File: rtl/mvm_lane_mac.sv
// One lane of the multiply-accumulator: registered x element, bit-serial partial
// product (MSB-first, MSB term negated) and the lane accumulator.
// Ports: clk/rst_n (sync active-low), clr (job start), load (beat accepted, capture x),
// x_in/x_signed, step (MAC cycle), w_bit/msb/last (current weight bit and its position),
// acc (registered accumulator), sat_c (combinational: this update clamped).
// With MVM_STREAM_ACC_SATURATE_EN defined the accumulator update clamps instead of wrapping.
module mvm_lane_mac
   import mvm_pkg::*;
#(
   parameter int unsigned NUM_BIT = DEF_NUM_BIT,
   parameter int unsigned WT_BIT  = DEF_WT_BIT,
   parameter int unsigned ACC_BIT = DEF_ACC_BIT
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic               clr,
   input  logic               load,
   input  logic [NUM_BIT-1:0] x_in,
   input  logic               x_signed,
   input  logic               step,
   input  logic               w_bit,
   input  logic               msb,
   input  logic               last,
   output logic [ACC_BIT-1:0] acc,
   output logic               sat_c
);

   localparam int unsigned PW = NUM_BIT + WT_BIT + 1;

   logic [NUM_BIT-1:0] x_q, x_d;
   logic [PW-1:0]      p_q, p_d, p_next;
   logic [ACC_BIT-1:0] acc_q, acc_d;
   logic [EXT_W-1:0]   xe, term, p_ext, acc_ext;
`ifdef MVM_STREAM_ACC_SATURATE_EN
   sat_res_t           res;
`endif

   // Bit-serial step and accumulator update.
   always_comb begin
      x_d   = x_q;
      p_d   = p_q;
      acc_d = acc_q;
      sat_c = 1'b0;

      xe   = ext_x(EXT_W'(x_q), NUM_BIT, x_signed);
      term = w_bit ? (msb ? -xe : xe) : EXT_W'(0);
      // The MSB cycle starts a fresh partial, so the stale p is discarded there.
      p_next  = PW'((msb ? EXT_W'(0) : (EXT_W'(p_q) << 1)) + term);
      p_ext   = ext_x(EXT_W'(p_next), PW, 1'b1);
      acc_ext = ext_x(EXT_W'(acc_q), ACC_BIT, 1'b1);
`ifdef MVM_STREAM_ACC_SATURATE_EN
      res = sat_add(acc_ext, p_ext, ACC_BIT);
`endif

      if (load) x_d = x_in;
      if (step) p_d = p_next;
      if (step && last) begin
`ifdef MVM_STREAM_ACC_SATURATE_EN
         acc_d = ACC_BIT'(res.val);
         sat_c = res.sat;
`else
         acc_d = ACC_BIT'(acc_ext + p_ext);
`endif
      end
      if (clr) acc_d = '0;
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         x_q   <= '0;
         p_q   <= '0;
         acc_q <= '0;
      end else begin
         x_q   <= x_d;
         p_q   <= p_d;
         acc_q <= acc_d;
      end
   end

   assign acc = acc_q;

endmodule

// File: rtl/mvm_stream_acc.sv
// Streaming matrix-vector multiply-accumulator: y[j] = sum_k w_k * x_k[j].
// Ports: i_clk_mvmAcc, i_rst_n_mvmAcc (sync active-low); i_start/i_num_vec/i_x_signed
// start a job; i_in_valid/o_in_ready with i_x_vector/i_wt carry column beats;
// o_y_valid/i_y_ready with o_y_vector deliver results; o_busy, o_sat status.
// Optional macro MVM_STREAM_ACC_SATURATE_EN: clamp accumulators and report via o_sat.
module mvm_stream_acc
   import mvm_pkg::*;
#(
   parameter int unsigned DIM     = DEF_DIM,
   parameter int unsigned NUM_BIT = DEF_NUM_BIT,
   parameter int unsigned WT_BIT  = DEF_WT_BIT,
   parameter int unsigned ACC_BIT = DEF_ACC_BIT,
   parameter int unsigned MAX_VEC = DEF_MAX_VEC,
   parameter int unsigned CNT_BIT = $clog2(MAX_VEC + 1)
) (
   input  logic                          i_clk_mvmAcc,
   input  logic                          i_rst_n_mvmAcc,
   input  logic                          i_start,
   input  logic [CNT_BIT-1:0]            i_num_vec,
   input  logic                          i_x_signed,
   input  logic                          i_in_valid,
   output logic                          o_in_ready,
   input  logic [DIM-1:0][NUM_BIT-1:0]   i_x_vector,
   input  logic [WT_BIT-1:0]             i_wt,
   output logic                          o_y_valid,
   input  logic                          i_y_ready,
   output logic [DIM-1:0][ACC_BIT-1:0]   o_y_vector,
   output logic                          o_busy,
   output logic                          o_sat
);

   localparam int unsigned BIT_W = (WT_BIT > 1) ? $clog2(WT_BIT) : 1;

   mvm_state_e         state_q, state_d;
   logic [CNT_BIT-1:0] cnt_q, cnt_d, num_q, num_d, num_clamp, cnt_inc;
   logic [WT_BIT-1:0]  w_q, w_d;
   logic [BIT_W-1:0]   bit_q, bit_d;
   logic               xs_q, xs_d, sat_q, sat_d;
   logic               in_ready_q, in_ready_d, y_valid_q, y_valid_d, busy_q, busy_d;
   logic               start_c, accept_c, step_c, msb_c, mac_last_c;
   logic [DIM-1:0]     lane_sat;

   assign num_clamp  = (i_num_vec > CNT_BIT'(MAX_VEC)) ? CNT_BIT'(MAX_VEC) : i_num_vec;
   assign cnt_inc    = cnt_q + CNT_BIT'(1);
   assign start_c    = (state_q == IDLE) && i_start;
   assign accept_c   = (state_q == RECV) && i_in_valid && in_ready_q;
   assign step_c     = (state_q == MAC);
   assign msb_c      = (bit_q == '0);
   assign mac_last_c = step_c && (bit_q == BIT_W'(WT_BIT - 1));

   // State register.
   always_ff @(posedge i_clk_mvmAcc) begin
      if (!i_rst_n_mvmAcc) state_q <= IDLE;
      else                 state_q <= state_d;
   end

   // Next-state logic.
   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE: if (i_start) state_d = (num_clamp == '0) ? DONE : RECV;
         RECV: begin
            if (accept_c) begin
               if (i_wt == '0) state_d = (cnt_inc == num_q) ? DONE : RECV;
               else            state_d = MAC;
            end
         end
         MAC:  if (mac_last_c) state_d = (cnt_q == num_q) ? DONE : RECV;
         DONE: if (y_valid_q && i_y_ready) state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   // Output and datapath next values; handshake outputs follow the next state.
   always_comb begin
      in_ready_d = (state_d == RECV);
      y_valid_d  = (state_d == DONE);
      busy_d     = (state_d != IDLE);
      cnt_d      = cnt_q;
      num_d      = num_q;
      xs_d       = xs_q;
      w_d        = w_q;
      bit_d      = bit_q;
      sat_d      = sat_q | (|lane_sat);

      if (start_c) begin
         cnt_d = '0;
         num_d = num_clamp;
         xs_d  = i_x_signed;
         sat_d = 1'b0;
      end
      if (accept_c) begin
         cnt_d = cnt_inc;
         w_d   = i_wt;
         bit_d = '0;
      end
      if (step_c) begin
         w_d   = w_q << 1;
         bit_d = bit_q + BIT_W'(1);
      end
   end

   always_ff @(posedge i_clk_mvmAcc) begin
      if (!i_rst_n_mvmAcc) begin
         cnt_q      <= '0;
         num_q      <= '0;
         xs_q       <= 1'b0;
         w_q        <= '0;
         bit_q      <= '0;
         sat_q      <= 1'b0;
         in_ready_q <= 1'b0;
         y_valid_q  <= 1'b0;
         busy_q     <= 1'b0;
      end else begin
         cnt_q      <= cnt_d;
         num_q      <= num_d;
         xs_q       <= xs_d;
         w_q        <= w_d;
         bit_q      <= bit_d;
         sat_q      <= sat_d;
         in_ready_q <= in_ready_d;
         y_valid_q  <= y_valid_d;
         busy_q     <= busy_d;
      end
   end

   // Lane array; weight MSB is consumed first as the shift register moves left.
   for (genvar j = 0; j < DIM; j++) begin : g_lane
      mvm_lane_mac #(
         .NUM_BIT(NUM_BIT),
         .WT_BIT (WT_BIT),
         .ACC_BIT(ACC_BIT)
      ) u_lane (
         .clk     (i_clk_mvmAcc),
         .rst_n   (i_rst_n_mvmAcc),
         .clr     (start_c),
         .load    (accept_c),
         .x_in    (i_x_vector[j]),
         .x_signed(xs_q),
         .step    (step_c),
         .w_bit   (w_q[WT_BIT-1]),
         .msb     (msb_c),
         .last    (mac_last_c),
         .acc     (o_y_vector[j]),
         .sat_c   (lane_sat[j])
      );
   end

   assign o_in_ready = in_ready_q;
   assign o_y_valid  = y_valid_q;
   assign o_busy     = busy_q;
   assign o_sat      = sat_q;

endmodule

// File: tb/tb_mvm_stream_acc.sv
// Self-checking bench for mvm_stream_acc (DIM=4, ACC_BIT=16, MAX_VEC=8).
// Expected results come from plain integer multiply/accumulate over the beats sent.
module tb_mvm_stream_acc;

   localparam int unsigned T_DIM = 4;
   localparam int unsigned T_NB  = 8;
   localparam int unsigned T_WB  = 8;
   localparam int unsigned T_ACC = 16;
   localparam int unsigned T_MAX = 8;
   localparam int unsigned T_CB  = $clog2(T_MAX + 1);

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic                           rst_n, i_start, i_x_signed, i_in_valid, i_y_ready;
   logic [T_CB-1:0]                i_num_vec;
   logic [T_DIM-1:0][T_NB-1:0]     i_x_vector;
   logic [T_WB-1:0]                i_wt;
   logic                           o_in_ready, o_y_valid, o_busy, o_sat;
   logic [T_DIM-1:0][T_ACC-1:0]    o_y_vector;

   mvm_stream_acc #(
      .DIM(T_DIM), .NUM_BIT(T_NB), .WT_BIT(T_WB), .ACC_BIT(T_ACC), .MAX_VEC(T_MAX)
   ) dut (
      .i_clk_mvmAcc  (clk),
      .i_rst_n_mvmAcc(rst_n),
      .i_start       (i_start),
      .i_num_vec     (i_num_vec),
      .i_x_signed    (i_x_signed),
      .i_in_valid    (i_in_valid),
      .o_in_ready    (o_in_ready),
      .i_x_vector    (i_x_vector),
      .i_wt          (i_wt),
      .o_y_valid     (o_y_valid),
      .i_y_ready     (i_y_ready),
      .o_y_vector    (o_y_vector),
      .o_busy        (o_busy),
      .o_sat         (o_sat)
   );

   int checks = 0;
   int failures = 0;
   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   logic [T_NB-1:0] bx [0:15][0:T_DIM-1];
   logic [T_WB-1:0] bw [0:15];
   int              wait_cnt [0:15];
   int              last_acc_cyc, first_valid_cyc;
   longint          exp_y [0:T_DIM-1];
   logic            exp_sat;

   // Reference: integer products summed per lane, wrapped or clamped per update.
   function automatic void model(input int n, input logic sgn);
      longint xv, wv, hi, lo;
      logic signed [T_ACC-1:0] t;
      hi = (longint'(1) <<< (T_ACC - 1)) - 1;
      lo = -(longint'(1) <<< (T_ACC - 1));
      exp_sat = 1'b0;
      for (int j = 0; j < T_DIM; j++) exp_y[j] = 0;
      for (int k = 0; k < n; k++) begin
         for (int j = 0; j < T_DIM; j++) begin
            xv = sgn ? longint'($signed(bx[k][j])) : longint'(bx[k][j]);
            wv = longint'($signed(bw[k]));
            exp_y[j] = exp_y[j] + xv * wv;
`ifdef MVM_STREAM_ACC_SATURATE_EN
            if (exp_y[j] > hi) begin exp_y[j] = hi; exp_sat = 1'b1; end
            if (exp_y[j] < lo) begin exp_y[j] = lo; exp_sat = 1'b1; end
`else
            t = T_ACC'(exp_y[j]);
            exp_y[j] = longint'(t);
`endif
         end
      end
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      rst_n = 1'b0; i_start = 1'b0; i_in_valid = 1'b0; i_y_ready = 1'b0;
      i_num_vec = '0; i_x_signed = 1'b0; i_x_vector = '0; i_wt = '0;
      repeat (2) tick();
      rst_n = 1'b1;
   endtask

   task automatic send_beat(input int k, output bit ok);
      int  w;
      bit  r;
      i_wt = bw[k];
      for (int j = 0; j < T_DIM; j++) i_x_vector[j] = bx[k][j];
      i_in_valid = 1'b1;
      ok = 1'b0;
      w = 0;
      while (!ok && w < 40) begin
         r = o_in_ready;
         tick();
         w++;
         if (r) ok = 1'b1;
      end
      i_in_valid = 1'b0;
      wait_cnt[k] = w;
      last_acc_cyc = cyc;
      if (!ok) begin
         checks++; failures++;
         $display("FAIL beat_accept beat=%0d not accepted within %0d cycles", k, w);
      end
   endtask

   task automatic run_job(input string name, input int n_req, input logic sgn, input int gap_max);
      int n_eff, w;
      bit ok;
      n_eff = (n_req > int'(T_MAX)) ? int'(T_MAX) : n_req;
      model(n_eff, sgn);
      i_num_vec = T_CB'(n_req); i_x_signed = sgn; i_start = 1'b1;
      tick();
      i_start = 1'b0;
      checks++;
      if (o_busy !== 1'b1) begin
         failures++; $display("FAIL %s busy_after_start got=%b want=1", name, o_busy);
      end
      for (int k = 0; k < n_eff; k++) begin
         if (gap_max > 0) repeat ($urandom_range(gap_max, 0)) tick();
         send_beat(k, ok);
         if (!ok) return;
      end
      w = 0;
      while (o_y_valid !== 1'b1 && w < 60) begin tick(); w++; end
      first_valid_cyc = cyc;
      checks++;
      if (o_y_valid !== 1'b1) begin
         failures++; $display("FAIL %s y_valid_timeout got=%b want=1", name, o_y_valid);
         return;
      end
      for (int j = 0; j < T_DIM; j++) begin
         checks++;
         if (o_y_vector[j] !== T_ACC'(exp_y[j])) begin
            failures++;
            $display("FAIL %s y[%0d] got=%0d want=%0d", name, j, $signed(o_y_vector[j]), exp_y[j]);
         end
      end
      checks++;
      if (o_sat !== exp_sat) begin
         failures++; $display("FAIL %s sat got=%b want=%b", name, o_sat, exp_sat);
      end
      i_y_ready = 1'b1;
      tick();
      i_y_ready = 1'b0;
      checks++;
      if (o_y_valid !== 1'b0 || o_busy !== 1'b0 || o_y_vector[0] !== T_ACC'(exp_y[0])) begin
         failures++;
         $display("FAIL %s after_accept valid=%b busy=%b y0=%0d want valid=0 busy=0 y0=%0d",
                  name, o_y_valid, o_busy, $signed(o_y_vector[0]), exp_y[0]);
      end
   endtask

   task automatic test_reset();
      checks++;
      if (o_in_ready !== 1'b0 || o_y_valid !== 1'b0 || o_busy !== 1'b0 || o_sat !== 1'b0 ||
          o_y_vector !== '0) begin
         failures++;
         $display("FAIL reset_state ready=%b valid=%b busy=%b sat=%b y=%h want all 0",
                  o_in_ready, o_y_valid, o_busy, o_sat, o_y_vector);
      end
   endtask

   task automatic test_basic();
      for (int j = 0; j < T_DIM; j++) begin
         bx[0][j] = T_NB'(j + 1);
         bx[1][j] = 8'hFF;
      end
      bw[0] = 8'd3;
      bw[1] = 8'hFE;
      run_job("basic", 2, 1'b1, 0);
      // o_y_valid rises WT_BIT edges after the accept edge: accept cycle + WT_BIT MAC cycles.
      checks++;
      if (first_valid_cyc - last_acc_cyc != int'(T_WB)) begin
         failures++;
         $display("FAIL basic_latency got=%0d want=%0d", first_valid_cyc - last_acc_cyc, T_WB);
      end
      checks++;
      if (wait_cnt[1] != int'(T_WB) + 1) begin
         failures++;
         $display("FAIL basic_beat_throughput got=%0d want=%0d", wait_cnt[1], T_WB + 1);
      end
      checks++;
      if (exp_y[0] != 5 || exp_y[3] != 14) begin
         failures++; $display("FAIL basic_model got=%0d,%0d want=5,14", exp_y[0], exp_y[3]);
      end
   endtask

   task automatic test_unsigned();
      bx[0][0] = 8'd255; bx[0][1] = 8'd0; bx[0][2] = 8'd1; bx[0][3] = 8'd128;
      bw[0] = 8'hFF;
      run_job("unsigned", 1, 1'b0, 0);
   endtask

   task automatic test_zero_skip();
      for (int k = 0; k < 3; k++)
         for (int j = 0; j < T_DIM; j++) bx[k][j] = 8'd7;
      bw[0] = 8'd0; bw[1] = 8'd0; bw[2] = 8'd1;
      run_job("zero_skip", 3, 1'b1, 0);
      for (int k = 0; k < 3; k++) begin
         checks++;
         if (wait_cnt[k] != 1) begin
            failures++; $display("FAIL zero_skip_ready beat=%0d wait got=%0d want=1", k, wait_cnt[k]);
         end
      end
   endtask

   task automatic test_empty_job();
      i_num_vec = '0; i_x_signed = 1'b1; i_start = 1'b1;
      tick();
      i_start = 1'b0;
      checks++;
      if (o_y_valid !== 1'b1 || o_in_ready !== 1'b0 || o_y_vector !== '0) begin
         failures++;
         $display("FAIL empty_done valid=%b ready=%b y=%h want valid=1 ready=0 y=0",
                  o_y_valid, o_in_ready, o_y_vector);
      end
      i_in_valid = 1'b1; i_wt = 8'd5; i_x_vector = '1;
      for (int i = 0; i < 10; i++) begin
         i_start = (i == 4);
         i_num_vec = 4'd3;
         tick();
         checks++;
         if (o_y_valid !== 1'b1 || o_in_ready !== 1'b0 || o_busy !== 1'b1 || o_y_vector !== '0) begin
            failures++;
            $display("FAIL empty_hold cyc=%0d valid=%b ready=%b busy=%b y=%h want 1,0,1,0",
                     i, o_y_valid, o_in_ready, o_busy, o_y_vector);
         end
      end
      i_start = 1'b0; i_in_valid = 1'b0; i_y_ready = 1'b1;
      tick();
      i_y_ready = 1'b0;
      checks++;
      if (o_y_valid !== 1'b0 || o_busy !== 1'b0) begin
         failures++; $display("FAIL empty_release valid=%b busy=%b want 0,0", o_y_valid, o_busy);
      end
   endtask

   task automatic test_reset_mid_mac();
      bit ok;
      for (int j = 0; j < T_DIM; j++) begin bx[0][j] = T_NB'(j + 5); bx[1][j] = 8'd3; end
      bw[0] = 8'd2; bw[1] = 8'd9;
      i_num_vec = 4'd2; i_x_signed = 1'b1; i_start = 1'b1;
      tick();
      i_start = 1'b0;
      send_beat(0, ok);
      send_beat(1, ok);
      repeat (3) tick();
      checks++;
      if (o_y_vector[0] !== 16'd10 || o_busy !== 1'b1) begin
         failures++;
         $display("FAIL midmac_pre y0=%0d busy=%b want 10,1", $signed(o_y_vector[0]), o_busy);
      end
      rst_n = 1'b0;
      tick();
      rst_n = 1'b1;
      checks++;
      if (o_busy !== 1'b0 || o_in_ready !== 1'b0 || o_y_valid !== 1'b0 || o_y_vector !== '0) begin
         failures++;
         $display("FAIL midmac_reset busy=%b ready=%b valid=%b y=%h want all 0",
                  o_busy, o_in_ready, o_y_valid, o_y_vector);
      end
      for (int k = 0; k < 2; k++) begin
         for (int j = 0; j < T_DIM; j++) bx[k][j] = T_NB'($urandom);
         bw[k] = T_WB'($urandom_range(255, 1));
      end
      run_job("after_reset", 2, 1'b1, 1);
   endtask

   task automatic test_saturation();
      logic [T_ACC-1:0] want;
      logic             want_sat;
      for (int k = 0; k < 3; k++) begin
         for (int j = 0; j < T_DIM; j++) bx[k][j] = 8'h80;
         bw[k] = 8'h80;
      end
      run_job("saturation", 3, 1'b1, 0);
`ifdef MVM_STREAM_ACC_SATURATE_EN
      want = 16'h7FFF; want_sat = 1'b1;
`else
      want = 16'hC000; want_sat = 1'b0;
`endif
      checks++;
      if (o_y_vector[2] !== want || o_sat !== want_sat) begin
         failures++;
         $display("FAIL saturation_const y2=%0d sat=%b want %0d,%b",
                  $signed(o_y_vector[2]), o_sat, $signed(want), want_sat);
      end
   endtask

   task automatic test_clamp();
      for (int k = 0; k < int'(T_MAX); k++) begin
         for (int j = 0; j < T_DIM; j++) bx[k][j] = T_NB'($urandom_range(15, 0));
         bw[k] = T_WB'($urandom_range(7, 0));
      end
      run_job("clamp", 13, 1'b0, 0);
   endtask

   task automatic test_random();
      int n;
      for (int t = 0; t < 6; t++) begin
         n = int'($urandom_range(T_MAX, 1));
         for (int k = 0; k < n; k++) begin
            for (int j = 0; j < T_DIM; j++) bx[k][j] = T_NB'($urandom);
            bw[k] = ($urandom_range(3, 0) == 0) ? 8'd0 : T_WB'($urandom);
         end
         run_job("random", n, 1'($urandom_range(1, 0)), 2);
      end
   endtask

   initial begin
      do_reset();
      test_reset();
      test_basic();
      test_unsigned();
      test_zero_skip();
      test_empty_job();
      test_reset_mid_mac();
      test_saturation();
      test_clamp();
      test_random();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
